// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and default sizing for the neuron MAC controller.
// The optional ReLU output stage is selected with the NEURON_RELU_EN macro.
package neuron_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int FRAC_BIT_DEF = 10;
  localparam int MAX_LEN_DEF  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_MAC   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/neuron_act.sv
// neuron_act: combinational output activation.
// With NEURON_RELU_EN defined negative accumulators are clamped to zero,
// otherwise the accumulator passes through untouched.
module neuron_act
  import neuron_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0] acc_i,
  output logic signed [WIDTH-1:0] act_o
);

`ifdef NEURON_RELU_EN
  assign act_o = acc_i[WIDTH-1] ? '0 : acc_i;
`else
  assign act_o = acc_i;
`endif

endmodule

// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl: sequences a dot product of length len over shared-address
// activation/weight memories through an external combinational MAC element,
// starting from bias, and presents the (optionally ReLU'd) result with a
// valid/ready handshake. Macro NEURON_RELU_EN enables the ReLU in neuron_act.
module neuron_mac_ctrl
  import neuron_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int FRAC_BIT = FRAC_BIT_DEF,
  parameter  int MAX_LEN  = MAX_LEN_DEF,
  localparam int ADDR_W   = $clog2(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W:0]          len,
  input  logic signed [WIDTH-1:0]  bias,
  output logic                     busy,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic signed [WIDTH-1:0]  act_data,
  input  logic signed [WIDTH-1:0]  wgt_data,
  output logic signed [WIDTH-1:0]  pe_a,
  output logic signed [WIDTH-1:0]  pe_b,
  output logic signed [WIDTH-1:0]  pe_y_in,
  input  logic signed [WIDTH-1:0]  pe_y_out,
  output logic                     out_valid,
  output logic signed [WIDTH-1:0]  out_data,
  input  logic                     out_ready
);

  // The fixed-point product scaling lives in the external MAC element; this
  // controller only needs the format to be meaningful for that element.
  if (FRAC_BIT < 0 || FRAC_BIT >= WIDTH) begin : g_bad_frac
    $error("neuron_mac_ctrl: FRAC_BIT must lie in [0, WIDTH-1]");
  end

  localparam logic [ADDR_W:0] MAX_LEN_L = (ADDR_W + 1)'(MAX_LEN);
  localparam logic [ADDR_W:0] ONE_L     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] TWO_L     = (ADDR_W + 1)'(2);

  state_e                   state_q;
  logic [ADDR_W:0]          len_q;
  logic [ADDR_W:0]          k_q;
  logic signed [WIDTH-1:0]  acc_q;
  logic                     rd_en_q;
  logic [ADDR_W-1:0]        addr_q;
  logic                     out_valid_q;

  logic [ADDR_W:0]          len_d;
  logic [ADDR_W:0]          k_inc;
  logic [ADDR_W:0]          k_inc2;
  logic                     last_elem;
  logic                     more_rd;
  logic signed [WIDTH-1:0]  act_y;

  // Oversized requests are clamped so addresses never exceed MAX_LEN-1.
  assign len_d     = (len > MAX_LEN_L) ? MAX_LEN_L : len;
  assign k_inc     = k_q + ONE_L;
  assign k_inc2    = k_q + TWO_L;
  assign last_elem = (k_inc == len_q);
  // While element k is accumulated, element k+1's data is already in flight,
  // so the read issued now is for k+2.
  assign more_rd   = (k_inc2 < len_q);

  // Control FSM with registered strobes; read for element k+1 is issued
  // during element k so data lands exactly when the MAC cycle needs it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q <= bias;
            if (len == '0) begin
              state_q     <= ST_OUT;
              out_valid_q <= 1'b1;
            end else begin
              len_q   <= len_d;
              state_q <= ST_FETCH;
              rd_en_q <= 1'b1;
              addr_q  <= '0;
            end
          end
        end
        ST_FETCH: begin
          state_q <= ST_MAC;
          k_q     <= '0;
          rd_en_q <= (ONE_L < len_q);
          addr_q  <= (ONE_L < len_q) ? ONE_L[ADDR_W-1:0] : '0;
        end
        ST_MAC: begin
          acc_q <= pe_y_out;
          if (last_elem) begin
            state_q     <= ST_OUT;
            out_valid_q <= 1'b1;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
          end else begin
            k_q     <= k_inc;
            rd_en_q <= more_rd;
            addr_q  <= more_rd ? k_inc2[ADDR_W-1:0] : '0;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // MAC operands are live only while accumulating; zero elsewhere.
  always_comb begin
    pe_a    = '0;
    pe_b    = '0;
    pe_y_in = '0;
    if (state_q == ST_MAC) begin
      pe_a    = act_data;
      pe_b    = wgt_data;
      pe_y_in = acc_q;
    end
  end

  neuron_act #(
    .WIDTH (WIDTH)
  ) u_act (
    .acc_i (acc_q),
    .act_o (act_y)
  );

  assign busy      = (state_q != ST_IDLE);
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? act_y : '0;

endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// Testbench for neuron_mac_ctrl: memories, MAC element and a dot-product
// reference model live here; honours NEURON_RELU_EN like the design.
module tb_neuron_mac_ctrl;

  localparam int W  = 16;
  localparam int F  = 10;
  localparam int ML = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   len;
  logic [W-1:0]  bias;
  logic          busy;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  act_data;
  logic [W-1:0]  wgt_data;
  logic [W-1:0]  pe_a, pe_b, pe_y_in, pe_y_out;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;

  logic [W-1:0]  act_mem [0:ML-1];
  logic [W-1:0]  wgt_mem [0:ML-1];
  int            rd_log[$];

  int n_cmp = 0;
  int n_bad = 0;

  neuron_mac_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .busy      (busy),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .act_data  (act_data),
    .wgt_data  (wgt_data),
    .pe_a      (pe_a),
    .pe_b      (pe_b),
    .pe_y_in   (pe_y_in),
    .pe_y_out  (pe_y_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // External MAC element: (a*b)>>F truncated, plus y.
  function automatic logic [W-1:0] pe_env(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] y);
    int p;
    logic [31:0] pv;
    p  = int'($signed(a)) * int'($signed(b));
    p  = p >>> F;
    pv = p;
    return y + pv[W-1:0];
  endfunction

  assign pe_y_out = pe_env(pe_a, pe_b, pe_y_in);

  // Synchronous memories with one-cycle read latency; every read is logged.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      act_data <= act_mem[mem_addr];
      wgt_data <= wgt_mem[mem_addr];
      rd_log.push_back(int'(mem_addr));
    end
  end

  // Reference: bias plus sum of scaled products, wrapped to W bits.
  function automatic logic [W-1:0] model(input int n, input logic [W-1:0] b);
    int acc;
    logic [31:0] t;
    logic [W-1:0] r;
    acc = int'($signed(b));
    for (int i = 0; i < n; i++)
      acc = acc + ((int'($signed(act_mem[i])) * int'($signed(wgt_mem[i]))) >>> F);
    t = acc;
    r = t[W-1:0];
`ifdef NEURON_RELU_EN
    if (r[W-1]) r = '0;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rand(input int shift);
    for (int i = 0; i < ML; i++) begin
      act_mem[i] = W'($signed(W'($urandom)) >>> shift);
      wgt_mem[i] = W'($signed(W'($urandom)) >>> shift);
    end
  endtask

  // Issue one operation and check latency, result, read trace and operands.
  task automatic do_op(input int n, input logic [W-1:0] b, input string tag);
    int eff, cyc, bad;
    logic [W-1:0] exp;
    eff = (n > ML) ? ML : n;
    exp = model(eff, b);
    rd_log.delete();
    @(negedge clk);
    len = (AW + 1)'(n);
    bias = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy1"}, busy, 1);
    check({tag, "_pe_first"}, {pe_a, pe_b, pe_y_in}, 0);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, (eff == 0) ? 1 : eff + 2);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_nreads"}, rd_log.size(), eff);
    bad = 0;
    for (int i = 0; i < rd_log.size(); i++)
      if (rd_log[i] != i) bad++;
    check({tag, "_addr_order"}, bad, 0);
    check({tag, "_pe_out"}, {pe_a, pe_b, pe_y_in}, 0);
  endtask

  task automatic accept_idle(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_valid"}, out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] hold_exp;
    int n;

    rst = 1'b1; start = 1'b0; len = '0; bias = '0; out_ready = 1'b1;
    act_data = '0; wgt_data = '0;
    for (int i = 0; i < ML; i++) begin act_mem[i] = '0; wgt_mem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_outs", {mem_addr, pe_a, pe_b, pe_y_in, out_data}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed three-element product.
    act_mem[0] = 16'h0400; act_mem[1] = 16'h0800; act_mem[2] = 16'h0200;
    wgt_mem[0] = 16'h0400; wgt_mem[1] = 16'h0400; wgt_mem[2] = 16'h0800;
    do_op(3, 16'h0000, "dir3");
    check("dir3_const", out_data, 16'h1000);
    accept_idle("dir3");

    // Zero length: result is the (activated) bias with no reads.
    do_op(0, 16'hFC00, "len0");
`ifdef NEURON_RELU_EN
    check("len0_const", out_data, 16'h0000);
`else
    check("len0_const", out_data, 16'hFC00);
`endif
    accept_idle("len0");

    // Large positive products wrap, never saturate.
    act_mem[0] = 16'h7C00; act_mem[1] = 16'h7C00;
    wgt_mem[0] = 16'h7C00; wgt_mem[1] = 16'h7C00;
    do_op(2, 16'h0000, "big2");
    check("big2_const", out_data, 16'h0800);
    accept_idle("big2");
    do_op(2, 16'h7E00, "wrap2");
`ifdef NEURON_RELU_EN
    check("wrap2_const", out_data, 16'h0000);
`else
    check("wrap2_const", out_data, 16'h8600);
`endif
    accept_idle("wrap2");

    // Result held while consumer stalls; start pulses are ignored.
    fill_rand(4);
    out_ready = 1'b0;
    hold_exp = model(4, 16'h0123);
    do_op(4, 16'h0123, "hold");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      len = 7'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("hold_data", out_data, hold_exp);
      check("hold_busy", busy, 1);
      check("hold_valid", out_valid, 1);
      check("hold_noreads", rd_log.size(), 4);
    end
    @(negedge clk);
    out_ready = 1'b1;
    accept_idle("hold");

    // Reset in the middle of accumulation.
    fill_rand(2);
    @(negedge clk);
    len = 7'd8;
    bias = 16'h0055;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("rstmac_busy", busy, 1);
    check("rstmac_rd_en", mem_rd_en, 1);
    check("rstmac_addr", mem_addr, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstmac_zero_ctl", {busy, mem_rd_en, out_valid}, 0);
    check("rstmac_zero_data", {mem_addr, pe_a, pe_b, pe_y_in, out_data}, 0);
    do_op(2, 16'h0010, "after_rst");
    accept_idle("after_rst");

    // Oversized length clamps to MAX_LEN.
    fill_rand(3);
    do_op(100, 16'h0200, "clamp");
    accept_idle("clamp");

    // Randomized lengths, data and bias.
    for (int r = 0; r < 8; r++) begin
      fill_rand(r % 4);
      n = int'($urandom_range(1, ML));
      do_op(n, W'($urandom), "rand");
      accept_idle("rand");
    end

    // Single-element edge case.
    fill_rand(0);
    do_op(1, W'($urandom), "len1");
    accept_idle("len1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
